// File: rtl/grid_pkg.sv
// Shared geometry, control-bit positions and command decode types for the
// LED frame builder.
package grid_pkg;

  localparam int unsigned NUM_COLS = 5;
  localparam int unsigned ROW_BITS = 8;
  localparam int unsigned GRID_W   = NUM_COLS * ROW_BITS;

  localparam int unsigned CTRL_COMMIT = 0;
  localparam int unsigned CTRL_CLEAR  = 1;
  localparam int unsigned CTRL_FORCE  = 2;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_CLEAR,
    CMD_ACCEPT,
    CMD_REJECT
  } cmd_e;

  // Column 1 lives in the most significant byte of the packed frame.
  function automatic logic [2:0] col_slot(input logic [2:0] col_idx);
    return 3'(NUM_COLS - 1) - col_idx;
  endfunction

endpackage

// File: rtl/grid_watchdog.sv
// Saturating idle-cycle counter; expire_o flags the last allowed cycle so the
// owner can drop its output on the following edge.
module grid_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 25000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i || !enable_i) begin
      count_d = '0;
    end else if (count_q != CNT_MAX) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (TIMEOUT_CYCLES != 0) && enable_i && (count_q == CNT_LAST);

endmodule

// File: rtl/grid_frame_builder.sv
// Snoops register-file writes into a double-buffered 5x8 LED frame with
// atomic commit, clear, and a watchdog that blanks a stale display.
module grid_frame_builder
  import grid_pkg::*;
#(
  parameter logic [4:0]  BASE_ADDR      = 5'd10,
  parameter logic [4:0]  COMMIT_ADDR    = 5'd15,
  parameter int unsigned TIMEOUT_CYCLES = 25000000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              reg_we,
  input  logic [4:0]        reg_waddr,
  input  logic [31:0]       reg_wdata,
  output logic [GRID_W-1:0] grid_values,
  output logic              grid_ready,
  output logic [7:0]        frame_count,
  output logic              commit_error
);

  localparam int unsigned LAST_COL = int'(BASE_ADDR) + NUM_COLS - 1;

  if ((BASE_ADDR == 5'd0) || (LAST_COL > 31) ||
      ((COMMIT_ADDR >= BASE_ADDR) && (int'(COMMIT_ADDR) <= LAST_COL))) begin : g_bad_addr_map
    $error("grid_frame_builder: column range overlaps address 0 or COMMIT_ADDR");
  end

  logic [NUM_COLS-1:0][ROW_BITS-1:0] shadow_q, shadow_d;
  logic [NUM_COLS-1:0][ROW_BITS-1:0] front_q,  front_d;
  logic [NUM_COLS-1:0]               dirty_q,  dirty_d;
  logic                              ready_q,  ready_d;
  logic [7:0]                        frames_q, frames_d;
  logic                              error_q,  error_d;

  logic [5:0] col_off;
  logic       col_hit;
  logic [2:0] col_idx;
  cmd_e       cmd;
  logic       wd_expire;
  logic       unused_wdata;

  assign unused_wdata = ^reg_wdata[31:ROW_BITS];

  assign col_off = {1'b0, reg_waddr} - {1'b0, BASE_ADDR};
  assign col_hit = reg_we && (reg_waddr != 5'd0) && (reg_waddr >= BASE_ADDR) &&
                   (col_off < 6'(NUM_COLS));
  assign col_idx = col_off[2:0];

  // CLEAR outranks COMMIT; FORCE only matters when COMMIT is set.
  always_comb begin
    cmd = CMD_NONE;
    if (reg_we && (reg_waddr == COMMIT_ADDR)) begin
      if (reg_wdata[CTRL_CLEAR]) begin
        cmd = CMD_CLEAR;
      end else if (reg_wdata[CTRL_COMMIT]) begin
        if ((dirty_q == '1) || reg_wdata[CTRL_FORCE]) begin
          cmd = CMD_ACCEPT;
        end else begin
          cmd = CMD_REJECT;
        end
      end
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    front_d  = front_q;
    dirty_d  = dirty_q;
    ready_d  = ready_q;
    frames_d = frames_q;
    error_d  = 1'b0;

    if (wd_expire) begin
      ready_d = 1'b0;
    end

    if (col_hit) begin
      shadow_d[col_slot(col_idx)] = reg_wdata[ROW_BITS-1:0];
      dirty_d[col_idx]            = 1'b1;
    end

    unique case (cmd)
      CMD_CLEAR: begin
        shadow_d = '0;
        front_d  = '0;
        dirty_d  = '0;
        ready_d  = 1'b0;
      end
      CMD_ACCEPT: begin
        front_d  = shadow_q;
        dirty_d  = '0;
        ready_d  = 1'b1;
        frames_d = frames_q + 8'd1;
      end
      CMD_REJECT: error_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shadow_q <= '0;
      front_q  <= '0;
      dirty_q  <= '0;
      ready_q  <= 1'b0;
      frames_q <= '0;
      error_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      front_q  <= front_d;
      dirty_q  <= dirty_d;
      ready_q  <= ready_d;
      frames_q <= frames_d;
      error_q  <= error_d;
    end
  end

  grid_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clock),
    .rst_ni   (resetn),
    .clear_i  ((cmd == CMD_CLEAR) || (cmd == CMD_ACCEPT)),
    .enable_i (ready_q),
    .expire_o (wd_expire)
  );

  assign grid_values  = front_q;
  assign grid_ready   = ready_q;
  assign frame_count  = frames_q;
  assign commit_error = error_q;

endmodule

// File: doc/grid_frame_builder.md
Name: grid_frame_builder

Overview:
- Snoops the processor register-file write port and assembles a 5-column x 8-row LED frame.
- Drives grid_values/grid_ready into the LED matrix driver in the top level.
- Double-buffered: software fills shadow columns, then commits atomically.
- A watchdog blanks the display if software stops committing frames.

Parameters:
BASE_ADDR, 5'd10, register address of column 1; columns 1..5 occupy BASE_ADDR..BASE_ADDR+4
COMMIT_ADDR, 5'd15, register address of the control/commit register
TIMEOUT_CYCLES, 25000000, cycles without a commit before grid_ready drops; 0 disables the watchdog

Ports:
clock  in  1  system clock (50 MHz)
resetn  in  1  asynchronous active-low reset
reg_we  in  1  register-file write enable
reg_waddr  in  5  register-file write address
reg_wdata  in  32  register-file write data
grid_values  out  40  front buffer; col1 in [39:32] through col5 in [7:0]; bit7 of each byte = row 1
grid_ready  out  1  front buffer is valid for display
frame_count  out  8  count of successful commits; wraps 255->0
commit_error  out  1  one-cycle pulse when an incomplete commit is rejected

Behaviour:
- Reset (async, resetn=0): shadow, front, dirty mask, watchdog counter, frame_count all 0; grid_ready=0; commit_error=0.
- Column write: reg_we & reg_waddr==BASE_ADDR+i (i=0..4).
  - shadow[i] <= reg_wdata[7:0]; upper data bits are ignored.
  - dirty[i] <= 1.
  - front is untouched.
- Address 0 is never acted on. Addresses outside the column range and COMMIT_ADDR are ignored.
- Commit-register write: reg_we & reg_waddr==COMMIT_ADDR. Decoded by priority:
  - reg_wdata[1] CLEAR: shadow, front and dirty <= 0; grid_ready <= 0; watchdog <= 0; frame_count unchanged.
  - else reg_wdata[0] COMMIT, accepted when dirty==5'b11111 or reg_wdata[2] FORCE:
    - front <= shadow; grid_ready <= 1; dirty <= 0; watchdog <= 0; frame_count <= frame_count+1.
    - Shadow contents are retained.
  - else COMMIT with incomplete dirty mask: commit_error=1 for exactly one cycle; no other state changes.
  - data bits [1:0]==0: no-op.
- Latency: all outputs are registered. The new front appears on grid_values and grid_ready=1 in the cycle after the commit edge.
- A column write in the cycle immediately after a commit updates the shadow only and sets dirty for the next frame.
- Watchdog (TIMEOUT_CYCLES!=0):
  - Counter increments each cycle while grid_ready=1.
  - When the counter reaches TIMEOUT_CYCLES-1, grid_ready <= 0 on the next edge. front is retained.
  - The counter holds at 0 while grid_ready=0.
  - A later accepted commit re-raises grid_ready.
- TIMEOUT_CYCLES=0: grid_ready is cleared only by CLEAR or reset.
- The single write port means at most one event per cycle; no simultaneous-event arbitration is needed.
- Reset asserted mid-frame discards partial shadow contents immediately.
- Elaboration check: the column range must not overlap COMMIT_ADDR and must not include address 0.

Decomposition:
- Package grid_pkg holds:
  - NUM_COLS=5, ROW_BITS=8, GRID_W=40.
  - Control bit indices CTRL_COMMIT=0, CTRL_CLEAR=1, CTRL_FORCE=2.
- One sub-module, grid_watchdog: parameterized saturating cycle counter with clear/enable inputs and an expire output. Counter width is $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Reset: hold resetn=0 -> grid_values=0, grid_ready=0, frame_count=0, commit_error=0.
- Full frame: write 0x81,0x42,0x24,0x18,0xFF to addr 10..14, then 0x1 to addr 15 -> next cycle grid_values=40'h81_42_24_18_FF, grid_ready=1, frame_count=1.
- Incomplete frame: write only addr 10 (0x55), then commit 0x1.
  - commit_error pulses one cycle; grid_values unchanged.
  - Recommit 0x5 (FORCE) -> col1=0x55, others take the prior shadow values, frame_count increments.
- CLEAR during display: write 0x2 to addr 15 -> grid_values=0 and grid_ready=0 next cycle; frame_count retained.
- Watchdog with TIMEOUT_CYCLES=8: after a commit, no further writes -> grid_ready falls exactly 8 cycles after rising; a new full commit restores it.
- Wrap and ignore:
  - 256 accepted commits -> frame_count returns to 0.
  - Writes to addr 0, addr 9 and addr 16, and writes with reg_we=0 -> no state change.
